// File: rtl/priority_decoder.sv
// Buffered 2-to-4 priority decoder: a 2-deep FIFO of {x,y,z} codes feeds a
// one-hot decoder, with saturating per-line and idle pop counters.
module priority_decoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             x,
    input  logic             y,
    input  logic             z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             D0,
    output logic             D1,
    output logic             D2,
    output logic             D3,
    input  logic             clr_cnt,
    input  logic [2:0]       cnt_sel,
    output logic [CNT_W-1:0] cnt_val
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    logic [2:0]       fifo_mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             rdy_q;
    logic [CNT_W-1:0] cnt [5];

    logic       push;
    logic       pop;
    logic [2:0] head;
    logic [2:0] pop_idx;
    logic [3:0] lines;

    assign in_ready  = rdy_q && (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign head      = fifo_mem[rd_ptr];
    // Idle codes (z=0) land in slot 4 so their x/y bits never touch a line counter.
    assign pop_idx   = head[0] ? {1'b0, head[2:1]} : 3'd4;

    always_comb begin
        lines = 4'b0000;
        if (out_valid && head[0]) begin
            lines = 4'b0001 << head[2:1];
        end
    end

    assign D0 = lines[0];
    assign D1 = lines[1];
    assign D2 = lines[2];
    assign D3 = lines[3];

    // Payload storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {x, y, z};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            rdy_q  <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 5; i++) begin
                cnt[i] <= '0;
            end
        end else if (clr_cnt) begin
            for (int i = 0; i < 5; i++) begin
                cnt[i] <= '0;
            end
        end else if (pop) begin
            for (int i = 0; i < 5; i++) begin
                if (pop_idx == 3'(i)) begin
                    cnt[i] <= sat_inc(cnt[i]);
                end
            end
        end
    end

    always_comb begin
        cnt_val = '0;
        case (cnt_sel)
            3'd0:    cnt_val = cnt[0];
            3'd1:    cnt_val = cnt[1];
            3'd2:    cnt_val = cnt[2];
            3'd3:    cnt_val = cnt[3];
            3'd4:    cnt_val = cnt[4];
            default: cnt_val = '0;
        endcase
    end

endmodule

// File: tb/tb_priority_decoder.sv
// Directed and randomized-stream bench for priority_decoder with 4-bit counters.
module tb_priority_decoder;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic             x, y, z;
    logic             out_valid;
    logic             out_ready;
    logic             D0, D1, D2, D3;
    logic             clr_cnt;
    logic [2:0]       cnt_sel;
    logic [CNT_W-1:0] cnt_val;

    int vectors = 0;
    int errs    = 0;

    priority_decoder #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .z         (z),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D0        (D0),
        .D1        (D1),
        .D2        (D2),
        .D3        (D3),
        .clr_cnt   (clr_cnt),
        .cnt_sel   (cnt_sel),
        .cnt_val   (cnt_val)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] decode(input logic [2:0] c);
        return c[0] ? (4'b0001 << c[2:1]) : 4'b0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [2:0] c, input logic ordy);
        in_valid  = iv;
        {x, y, z} = c;
        out_ready = ordy;
    endtask

    task automatic chk_out(input string tag, input logic ov, input logic ir, input logic [3:0] d);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
        chk({tag, ".in_ready"},  32'(in_ready),  32'(ir));
        chk({tag, ".D"},         32'({D3, D2, D1, D0}), 32'(d));
    endtask

    task automatic chk_cnt(input string tag, input int sel, input int exp);
        cnt_sel = 3'(sel);
        #1;
        chk($sformatf("%s.cnt%0d", tag, sel), 32'(cnt_val), 32'(exp));
    endtask

    logic [2:0] q[$];
    int         mcnt[5];
    int         sent, popped, cyc;
    logic [2:0] code, h;
    logic       iv, ordy, do_push, do_pop, do_clr;

    initial begin
        rst_n = 1'b0; clr_cnt = 1'b0; cnt_sel = 3'd0;
        drive(1'b0, 3'b000, 1'b0);
        tick(); tick();
        chk_out("reset", 1'b0, 1'b0, 4'b0000);
        for (int i = 0; i < 5; i++) chk_cnt("reset", i, 0);
        chk_cnt("reset_sel7", 7, 0);

        rst_n = 1'b1;
        tick();
        chk_out("release", 1'b0, 1'b1, 4'b0000);

        // Single code 101 -> D2, visible right after the accepting edge
        drive(1'b1, 3'b101, 1'b1);
        tick();
        chk_out("push101", 1'b1, 1'b1, 4'b0100);
        drive(1'b0, 3'b000, 1'b1);
        tick();
        chk_out("pop101", 1'b0, 1'b1, 4'b0000);
        chk_cnt("pop101", 2, 1);

        // Fill under backpressure, third push refused, then drain in order
        drive(1'b1, 3'b111, 1'b0);
        tick();
        chk_out("bp_one", 1'b1, 1'b1, 4'b1000);
        drive(1'b1, 3'b001, 1'b0);
        tick();
        chk_out("bp_full", 1'b1, 1'b0, 4'b1000);
        drive(1'b1, 3'b010, 1'b0);
        tick();
        chk_out("bp_hold", 1'b1, 1'b0, 4'b1000);
        drive(1'b0, 3'b000, 1'b1);
        tick();
        chk_out("drain1", 1'b1, 1'b1, 4'b0001);
        tick();
        chk_out("drain2", 1'b0, 1'b1, 4'b0000);
        chk_cnt("drain", 3, 1);
        chk_cnt("drain", 0, 1);
        chk_cnt("drain", 1, 0);

        // Idle codes: x/y ignored when z=0
        clr_cnt = 1'b1;
        drive(1'b0, 3'b000, 1'b0);
        tick();
        clr_cnt = 1'b0;
        for (int i = 0; i < 5; i++) chk_cnt("clr", i, 0);
        drive(1'b1, 3'b000, 1'b1);
        tick();
        chk_out("idle000", 1'b1, 1'b1, 4'b0000);
        drive(1'b1, 3'b110, 1'b1);
        tick();
        chk_out("idle110", 1'b1, 1'b1, 4'b0000);
        drive(1'b0, 3'b000, 1'b1);
        tick();
        chk_out("idle_empty", 1'b0, 1'b1, 4'b0000);
        chk_cnt("idle", 4, 2);
        for (int i = 0; i < 4; i++) chk_cnt("idle", i, 0);

        // Saturation: 20 pops of 011 into a 4-bit counter
        drive(1'b1, 3'b011, 1'b1);
        for (int i = 0; i < 20; i++) tick();
        drive(1'b0, 3'b000, 1'b1);
        tick();
        chk_out("sat_empty", 1'b0, 1'b1, 4'b0000);
        chk_cnt("sat", 1, 15);
        drive(1'b1, 3'b011, 1'b0);
        tick();
        drive(1'b0, 3'b000, 1'b1);
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        chk_out("clr_pop", 1'b0, 1'b1, 4'b0000);
        chk_cnt("clr_pop", 1, 0);

        // Reset with two entries held and a pop pending
        drive(1'b1, 3'b011, 1'b1);
        tick();
        drive(1'b0, 3'b000, 1'b1);
        tick();
        chk_cnt("pre_rst", 1, 1);
        drive(1'b1, 3'b111, 1'b0);
        tick();
        drive(1'b1, 3'b001, 1'b0);
        tick();
        chk_out("pre_rst_full", 1'b1, 1'b0, 4'b1000);
        rst_n = 1'b0;
        drive(1'b1, 3'b101, 1'b1);
        tick();
        chk_out("mid_rst", 1'b0, 1'b0, 4'b0000);
        for (int i = 0; i < 5; i++) chk_cnt("mid_rst", i, 0);
        rst_n = 1'b1;
        drive(1'b0, 3'b000, 1'b0);
        tick();
        chk_out("post_rst", 1'b0, 1'b1, 4'b0000);

        // Random streaming against a queue model
        for (int i = 0; i < 5; i++) mcnt[i] = 0;
        sent = 0; popped = 0; cyc = 0;
        while ((sent < 1000 || q.size() > 0) && cyc < 20000) begin
            chk_out("rand", q.size() > 0, q.size() < 2, (q.size() > 0) ? decode(q[0]) : 4'b0000);
            do_clr = 1'b0;
            if (cyc % 64 == 63) begin
                for (int i = 0; i < 5; i++) chk_cnt("rand", i, mcnt[i]);
                do_clr = 1'b1;
            end
            iv   = (sent < 1000) && ($urandom_range(0, 3) != 0);
            code = 3'($urandom_range(0, 7));
            ordy = ($urandom_range(0, 2) != 0);
            drive(iv, code, ordy);
            clr_cnt = do_clr;
            do_push = iv && (q.size() < 2);
            do_pop  = ordy && (q.size() > 0);
            tick();
            if (do_pop) begin
                h = q.pop_front();
                popped++;
                if (h[0]) begin
                    if (mcnt[h[2:1]] < 15) mcnt[h[2:1]]++;
                end else if (mcnt[4] < 15) begin
                    mcnt[4]++;
                end
            end
            if (do_clr) begin
                for (int i = 0; i < 5; i++) mcnt[i] = 0;
            end
            if (do_push) begin
                q.push_back(code);
                sent++;
            end
            cyc++;
        end
        clr_cnt = 1'b0;
        drive(1'b0, 3'b000, 1'b0);
        chk("rand_sent", 32'(sent), 32'd1000);
        chk("rand_popped", 32'(popped), 32'd1000);
        chk_out("rand_end", 1'b0, 1'b1, 4'b0000);
        for (int i = 0; i < 5; i++) chk_cnt("rand_end", i, mcnt[i]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
